leaf_tx_packetizer: RTL and testbench



---
 rtl/bft_pkt_pkg.sv | 27 ++
 rtl/leaf_tx_packetizer_if.sv | 29 ++
 rtl/tx_credit_counter.sv | 41 ++++
 rtl/leaf_tx_packetizer.sv | 120 ++++++++++++
 tb/tb_leaf_tx_packetizer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bft_pkt_pkg.sv
// Shared BFT packet layout, default widths and transmit FSM encoding.
// Used by the leaf transmit packetizer and its credit counter.
package bft_pkt_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int NUM_BRAM_ADDR_BITS    = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int CREDIT_PORT           = 1;

  // Field positions, LSB first: payload | addr | port | leaf | valid
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_SEND   = 2'd1,
    TX_RESEND = 2'd2
  } tx_state_e;

endpackage

// File: rtl/leaf_tx_packetizer_if.sv
// Bundle of the user stream, BFT and debug signals of the leaf transmit packetizer.
// master = producer/BFT side, slave = packetizer.
interface leaf_tx_packetizer_if;
  import bft_pkt_pkg::*;

  // vld_user2tx is held with din_user stable until a one-cycle ack_tx2user;
  // the BFT side has no backpressure, so each dout_tx2bft packet lasts one cycle.
  logic [NUM_LEAF_BITS-1:0]      dest_leaf;
  logic [NUM_PORT_BITS-1:0]      dest_port;
  logic [PAYLOAD_BITS-1:0]       din_user;
  logic                          vld_user2tx;
  logic                          ack_tx2user;
  logic [PACKET_BITS-1:0]        dout_tx2bft;
  logic [PACKET_BITS-1:0]        din_bft2tx;
  logic                          resend;
  logic [NUM_BRAM_ADDR_BITS:0]   credit_avail;
  tx_state_e                     fsm_state;

  modport master (
    output dest_leaf, dest_port, din_user, vld_user2tx, din_bft2tx, resend,
    input  ack_tx2user, dout_tx2bft, credit_avail, fsm_state
  );

  modport slave (
    input  dest_leaf, dest_port, din_user, vld_user2tx, din_bft2tx, resend,
    output ack_tx2user, dout_tx2bft, credit_avail, fsm_state
  );

endinterface

// File: rtl/tx_credit_counter.sv
// Receiver-buffer credit: starts full, -1 per issued packet, +RETURN_SIZE per
// freespace update, saturating at MAX_CREDIT.
module tx_credit_counter #(
  parameter int CREDIT_BITS = bft_pkt_pkg::NUM_BRAM_ADDR_BITS + 1,
  parameter int MAX_CREDIT  = 2 ** bft_pkt_pkg::NUM_BRAM_ADDR_BITS,
  parameter int RETURN_SIZE = bft_pkt_pkg::FREESPACE_UPDATE_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   consume,
  input  logic                   return_pulse,
  output logic [CREDIT_BITS-1:0] credit,
  output logic                   has_credit
);

  logic [CREDIT_BITS-1:0] credit_q;
  logic [CREDIT_BITS:0]   sum;
  logic                   take;

  assign has_credit = (credit_q != '0);
  assign take       = consume && has_credit;
  assign credit     = credit_q;

  // One extra bit of headroom so the add can be saturated after the subtract
  always_comb begin
    sum = {1'b0, credit_q}
        + (return_pulse ? (CREDIT_BITS+1)'(RETURN_SIZE) : '0)
        - {{CREDIT_BITS{1'b0}}, take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q <= CREDIT_BITS'(MAX_CREDIT);
    end else if (sum > (CREDIT_BITS+1)'(MAX_CREDIT)) begin
      credit_q <= CREDIT_BITS'(MAX_CREDIT);
    end else begin
      credit_q <= sum[CREDIT_BITS-1:0];
    end
  end

endmodule

// File: rtl/leaf_tx_packetizer.sv
// Wraps 32-bit user words into addressed BFT packets under receiver credit,
// with single-packet retransmit on request.
module leaf_tx_packetizer #(
  parameter int PACKET_BITS           = bft_pkt_pkg::PACKET_BITS,
  parameter int PAYLOAD_BITS          = bft_pkt_pkg::PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS         = bft_pkt_pkg::NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS         = bft_pkt_pkg::NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS         = bft_pkt_pkg::NUM_ADDR_BITS,
  parameter int NUM_BRAM_ADDR_BITS    = bft_pkt_pkg::NUM_BRAM_ADDR_BITS,
  parameter int FREESPACE_UPDATE_SIZE = bft_pkt_pkg::FREESPACE_UPDATE_SIZE,
  parameter int CREDIT_PORT           = bft_pkt_pkg::CREDIT_PORT
) (
  input logic               clk,
  input logic               reset,
  leaf_tx_packetizer_if.slave bus
);

  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;

  bft_pkt_pkg::tx_state_e     state_q, state_d;
  logic [PACKET_BITS-1:0]     dout_q, dout_d;
  logic [PACKET_BITS-1:0]     last_q, last_d;
  logic [PACKET_BITS-1:0]     new_pkt;
  logic [NUM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic                       ack_q, ack_d;
  logic                       have_last_q, have_last_d;
  logic                       pend_q, pend_d;
  logic                       consume;
  logic                       credit_return;
  logic                       has_credit;
  logic [CREDIT_BITS-1:0]     credit;
  logic                       unused_bft_bits;

  assign credit_return = bus.din_bft2tx[bft_pkt_pkg::VALID_BIT]
    && (bus.din_bft2tx[bft_pkt_pkg::PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_PORT));
  assign unused_bft_bits = ^bus.din_bft2tx;

  always_comb begin
    new_pkt = '0;
    new_pkt[bft_pkt_pkg::PAYLOAD_LSB +: PAYLOAD_BITS]  = bus.din_user;
    new_pkt[bft_pkt_pkg::ADDR_LSB    +: NUM_ADDR_BITS] = addr_q;
    new_pkt[bft_pkt_pkg::PORT_LSB    +: NUM_PORT_BITS] = bus.dest_port;
    new_pkt[bft_pkt_pkg::LEAF_LSB    +: NUM_LEAF_BITS] = bus.dest_leaf;
    new_pkt[bft_pkt_pkg::VALID_BIT]                    = 1'b1;
  end

  tx_credit_counter #(
    .CREDIT_BITS (CREDIT_BITS),
    .MAX_CREDIT  (2 ** NUM_BRAM_ADDR_BITS),
    .RETURN_SIZE (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk          (clk),
    .reset        (reset),
    .consume      (consume),
    .return_pulse (credit_return),
    .credit       (credit),
    .has_credit   (has_credit)
  );

  // Decisions are made in IDLE and land in registers, so SEND/RESEND are the
  // cycles in which the packet is on the BFT port.
  always_comb begin
    state_d     = bft_pkt_pkg::TX_IDLE;
    dout_d      = '0;
    ack_d       = 1'b0;
    addr_d      = addr_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    pend_d      = pend_q;
    consume     = 1'b0;
    case (state_q)
      bft_pkt_pkg::TX_IDLE: begin
        pend_d = 1'b0;
        if ((bus.resend || pend_q) && have_last_q) begin
          state_d = bft_pkt_pkg::TX_RESEND;
          dout_d  = last_q;
        end else if (bus.vld_user2tx && has_credit) begin
          state_d     = bft_pkt_pkg::TX_SEND;
          dout_d      = new_pkt;
          ack_d       = 1'b1;
          addr_d      = addr_q + NUM_ADDR_BITS'(1);
          last_d      = new_pkt;
          have_last_d = 1'b1;
          consume     = 1'b1;
        end
      end
      bft_pkt_pkg::TX_SEND, bft_pkt_pkg::TX_RESEND: begin
        // A resend request that arrives while busy is held for the next IDLE
        if (bus.resend) pend_d = 1'b1;
      end
      default: state_d = bft_pkt_pkg::TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= bft_pkt_pkg::TX_IDLE;
      dout_q      <= '0;
      ack_q       <= 1'b0;
      addr_q      <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      ack_q       <= ack_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.dout_tx2bft  = dout_q;
  assign bus.ack_tx2user  = ack_q;
  assign bus.credit_avail = credit;
  assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// Directed bench for leaf_tx_packetizer: expected packets are queued as words
// are presented and checked in order as they appear on the BFT port.
module tb_leaf_tx_packetizer;
  import bft_pkt_pkg::*;

  logic clk = 1'b0;
  logic reset;

  leaf_tx_packetizer_if bus();

  leaf_tx_packetizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pkt_count = 0;
  int pushed = 0;
  int n0;
  int m_credit;
  logic [6:0] m_addr;
  logic [PACKET_BITS-1:0] exp_q[$];
  logic [PACKET_BITS-1:0] last_seen;
  logic [PACKET_BITS-1:0] last_exp;
  logic [PACKET_BITS-1:0] cred_pkt;
  logic [PACKET_BITS-1:0] exp_pkt;
  logic flag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PACKET_BITS-1:0] mk_pkt(input logic [4:0] leaf, input logic [3:0] port,
                                                    input logic [6:0] addr, input logic [31:0] data);
    return {1'b1, leaf, port, addr, data};
  endfunction

  // Scoreboard: every valid packet on the BFT port must match the queue head
  always @(negedge clk) begin
    if (bus.dout_tx2bft[VALID_BIT] === 1'b1) begin
      pkt_count++;
      last_seen = bus.dout_tx2bft;
      if (exp_q.size() == 0) begin
        chk("pkt_unexpected", 64'(bus.dout_tx2bft), 64'(0));
      end else begin
        exp_pkt = exp_q.pop_front();
        chk("pkt", 64'(bus.dout_tx2bft), 64'(exp_pkt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_issue(input logic [31:0] data);
    logic [PACKET_BITS-1:0] p;
    p = mk_pkt(bus.dest_leaf, bus.dest_port, m_addr, data);
    exp_q.push_back(p);
    pushed++;
    last_exp = p;
    m_addr = m_addr + 7'd1;
    m_credit = m_credit - 1;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack_tx2user !== 1'b1 && n < 8);
    chk(tag, 64'(bus.ack_tx2user), 64'(1));
  endtask

  task automatic send_word(input logic [31:0] data);
    bus.din_user = data;
    bus.vld_user2tx = 1'b1;
    expect_issue(data);
    wait_ack("word_ack");
    @(posedge clk); #1;
    bus.vld_user2tx = 1'b0;
  endtask

  task automatic inject_credit();
    bus.din_bft2tx = cred_pkt;
    m_credit = (m_credit + 64 > 128) ? 128 : m_credit + 64;
    @(posedge clk); #1;
    bus.din_bft2tx = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.vld_user2tx = 1'b0;
    bus.resend = 1'b0;
    bus.din_bft2tx = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_dout", 64'(bus.dout_tx2bft), 64'(0));
    chk("rst_ack", 64'(bus.ack_tx2user), 64'(0));
    chk("rst_credit", 64'(bus.credit_avail), 64'(128));
    chk("rst_state", 64'(bus.fsm_state), 64'(TX_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    m_credit = 128;
    m_addr = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.dest_leaf = 5'd3;
    bus.dest_port = 4'd2;
    bus.din_user = '0;
    bus.vld_user2tx = 1'b0;
    bus.din_bft2tx = '0;
    bus.resend = 1'b0;
    cred_pkt = mk_pkt(5'd0, 4'd1, 7'd0, 32'd0);
    do_reset();

    // Single word, vld left high into the SEND cycle
    bus.din_user = 32'hDEADBEEF;
    bus.vld_user2tx = 1'b1;
    expect_issue(32'hDEADBEEF);
    @(negedge clk);
    chk("single_ack_before", 64'(bus.ack_tx2user), 64'(0));
    @(negedge clk);
    chk("single_ack", 64'(bus.ack_tx2user), 64'(1));
    chk("single_credit", 64'(bus.credit_avail), 64'(127));
    chk("single_dout", 64'(bus.dout_tx2bft), 64'(mk_pkt(5'd3, 4'd2, 7'd0, 32'hDEADBEEF)));
    @(negedge clk);
    chk("stale_vld_ack", 64'(bus.ack_tx2user), 64'(0));
    chk("stale_vld_dout", 64'(bus.dout_tx2bft), 64'(0));
    bus.vld_user2tx = 1'b0;

    // Credit exhaustion and refill with address wrap
    bus.dest_leaf = 5'd17;
    bus.dest_port = 4'd9;
    do_reset();
    for (int i = 0; i < 128; i++) send_word($urandom);
    chk("exhaust_last_addr", 64'(last_seen[38:32]), 64'(127));
    chk("exhaust_credit", 64'(bus.credit_avail), 64'(0));
    bus.din_user = 32'hA5A5_0129;
    bus.vld_user2tx = 1'b1;
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack_tx2user !== 1'b0) flag = 1'b1;
    end
    chk("exhaust_no_ack", 64'(flag), 64'(0));
    chk("exhaust_credit_held", 64'(bus.credit_avail), 64'(0));
    inject_credit();
    chk("return_credit", 64'(bus.credit_avail), 64'(64));
    expect_issue(32'hA5A5_0129);
    wait_ack("word129_ack");
    @(posedge clk); #1;
    bus.vld_user2tx = 1'b0;
    send_word(32'hA5A5_0130);
    chk("refill_addr1", 64'(last_seen[38:32]), 64'(1));
    chk("refill_credit", 64'(bus.credit_avail), 64'(62));

    // Saturation and simultaneous send + return
    do_reset();
    for (int i = 0; i < 28; i++) send_word($urandom_range(0, 32'hFFFF));
    chk("sat_credit100", 64'(bus.credit_avail), 64'(100));
    inject_credit();
    chk("sat_credit128", 64'(bus.credit_avail), 64'(128));
    for (int i = 0; i < 118; i++) send_word($urandom);
    chk("sat_credit10", 64'(bus.credit_avail), 64'(10));
    bus.din_user = 32'hC0FFEE00;
    bus.vld_user2tx = 1'b1;
    bus.din_bft2tx = cred_pkt;
    m_credit = m_credit + 64;
    expect_issue(32'hC0FFEE00);
    @(posedge clk); #1;
    bus.din_bft2tx = '0;
    chk("sat_same_cycle", 64'(bus.credit_avail), 64'(73));
    wait_ack("same_cycle_ack");
    @(posedge clk); #1;
    bus.vld_user2tx = 1'b0;
    // Non-credit port packet must be ignored
    bus.din_bft2tx = mk_pkt(5'd0, 4'd2, 7'd0, 32'd0);
    @(posedge clk); #1;
    bus.din_bft2tx = '0;
    chk("other_port_ignored", 64'(bus.credit_avail), 64'(m_credit));

    // Resend of the last packet
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'h1000 + i);
    send_word(32'h11111111);
    chk("resend_src_addr", 64'(last_seen[38:32]), 64'(5));
    bus.resend = 1'b1;
    exp_q.push_back(last_exp);
    pushed++;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    @(negedge clk);
    chk("resend_ack", 64'(bus.ack_tx2user), 64'(0));
    chk("resend_dout", 64'(bus.dout_tx2bft), 64'(mk_pkt(5'd17, 4'd9, 7'd5, 32'h11111111)));
    chk("resend_credit", 64'(bus.credit_avail), 64'(122));
    @(negedge clk);
    chk("resend_single_cycle", 64'(bus.dout_tx2bft), 64'(0));
    send_word(32'h22222222);
    chk("resend_addr_kept", 64'(last_seen[38:32]), 64'(6));
    chk("resend_credit_after", 64'(bus.credit_avail), 64'(121));

    // Resend pulse during SEND is held until IDLE
    bus.din_user = 32'h33333333;
    bus.vld_user2tx = 1'b1;
    expect_issue(32'h33333333);
    wait_ack("latched_ack");
    bus.resend = 1'b1;
    exp_q.push_back(last_exp);
    pushed++;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    bus.vld_user2tx = 1'b0;
    repeat (3) @(negedge clk);
    chk("latched_resend_drained", 64'(exp_q.size()), 64'(0));

    // Resend has priority over a simultaneous new word
    bus.din_user = 32'h44444444;
    bus.vld_user2tx = 1'b1;
    bus.resend = 1'b1;
    exp_q.push_back(last_exp);
    pushed++;
    expect_issue(32'h44444444);
    @(posedge clk); #1;
    bus.resend = 1'b0;
    @(negedge clk);
    chk("prio_resend_noack", 64'(bus.ack_tx2user), 64'(0));
    chk("prio_resend_dout", 64'(bus.dout_tx2bft), 64'(mk_pkt(5'd17, 4'd9, 7'd7, 32'h33333333)));
    @(negedge clk);
    chk("prio_gap", 64'(bus.dout_tx2bft), 64'(0));
    @(negedge clk);
    chk("prio_new_ack", 64'(bus.ack_tx2user), 64'(1));
    @(posedge clk); #1;
    bus.vld_user2tx = 1'b0;

    // Resend with nothing sent since reset
    do_reset();
    n0 = pkt_count;
    bus.resend = 1'b1;
    @(posedge clk); #1;
    bus.resend = 1'b0;
    repeat (3) @(negedge clk);
    chk("resend_no_last", 64'(pkt_count - n0), 64'(0));

    // Reset during the SEND cycle
    bus.din_user = 32'h55555555;
    bus.vld_user2tx = 1'b1;
    expect_issue(32'h55555555);
    wait_ack("midrst_ack");
    #1;
    reset = 1'b1;
    bus.vld_user2tx = 1'b0;
    @(negedge clk);
    chk("midrst_dout", 64'(bus.dout_tx2bft), 64'(0));
    chk("midrst_ack", 64'(bus.ack_tx2user), 64'(0));
    chk("midrst_credit", 64'(bus.credit_avail), 64'(128));
    chk("midrst_state", 64'(bus.fsm_state), 64'(TX_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    m_credit = 128;
    m_addr = '0;
    send_word(32'h66666666);
    chk("midrst_addr0", 64'(last_seen[38:32]), 64'(0));
    chk("midrst_credit_after", 64'(bus.credit_avail), 64'(127));

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("pkt_count", 64'(pkt_count), 64'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
